cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  Coprocessor-0 register file. Consumes the system-control signals the main decoder produces (syscall, breakk, reserve_instruction, eret, mtcp0, mfcp0), plus exception info from the memory stage.
//  Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  Records exception state, serves mfc0 reads and mtc0 writes, and raises the interrupt request to the exception unit.
// PARAMETERS
//  RESET_STATUS  32'h0040_0000  Status value at reset (BEV=1, EXL=0, IE=0)
//  COUNT_DIV     2              Count increments once every COUNT_DIV clocks (1 or 2 only)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous, active-high reset
//  we_i          in   1   mtc0 write strobe
//  waddr_i       in   5   mtc0 destination register number (rd field)
//  wdata_i       in   32  mtc0 write data
//  raddr_i       in   5   mfc0 source register number
//  rdata_o       out  32  mfc0 read data (combinational)
//  int_i         in   6   external hardware interrupts, level, active-high
//  exc_valid_i   in   1   exception commits this cycle (from syscall/break/RI/Ov/AdE/Int)
//  exc_code_i    in   5   ExcCode of committing exception
//  eret_i        in   1   eret commits this cycle
//  pc_i          in   32  PC of committing instruction
//  in_delay_i    in   1   committing instruction is in a branch delay slot
//  bad_addr_i    in   32  faulting address for AdEL/AdES
//  status_o      out  32  current Status
//  cause_o       out  32  current Cause
//  epc_o         out  32  current EPC (eret target)
//  int_req_o     out  1   interrupt pending and enabled
//  timer_int_o   out  1   timer interrupt flag (Cause.TI)
// BEHAVIOUR
//  Reset: Status=RESET_STATUS; BadVAddr, Count, Compare, Cause, EPC = 0; divider = 0; all outputs follow from these.
//  Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
//  Reads of any other number return 0; writes to them are ignored.
//  Read path: rdata_o = register[raddr_i].
//  Forwarding: if we_i && waddr_i==raddr_i, rdata_o returns the post-write value (writable-field mask applied).
//  Writable fields:
//   - Status: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; other bits read 0.
//   - Cause: IP[9:8] only.
//   - EPC, Count, Compare: all 32 bits.
//   - BadVAddr: read-only.
//  Cause.IP[15:10]: sampled every cycle from int_i[5:0]; IP[15] = int_i[5] | TI.
//  Priority per cycle: exc_valid_i > eret_i > we_i. A lower-priority event coinciding with a higher one is dropped entirely.
//  Exception commit:
//   - If Status.EXL=0: EPC <= in_delay_i ? pc_i-4 : pc_i; Cause.BD[31] <= in_delay_i.
//   - If Status.EXL=1: EPC and BD are unchanged.
//   - Always: Status.EXL <= 1; Cause.ExcCode[6:2] <= exc_code_i.
//   - exc_code_i = 4 (AdEL) or 5 (AdES): BadVAddr <= bad_addr_i.
//  eret commit: Status.EXL <= 0; nothing else changes.
//  int_req_o = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]); combinational from registers.
//  Timer (see CONFIGURATION):
//   - Count advances when the divider wraps; a Count write reloads Count and clears the divider.
//   - Count wraps 32'hFFFF_FFFF -> 0 silently.
//   - When the registered Count == Compare and Compare != 0, Cause.TI[30] <= 1, one cycle after equality.
//   - A Compare write clears TI in the same edge; the write wins over a simultaneous set.
//  A reset asserted mid-operation discards any event in that cycle.
// CONFIGURATION
//  CP0_TIMER_EN defined: Count/Compare/TI logic as above.
//  CP0_TIMER_EN undefined:
//   - Count and Compare read 0 and writes to them are ignored.
//   - TI is held 0; timer_int_o = 0; IP[15] = int_i[5].
// STRUCTURE
//  defines.vh: CP0 register numbers (CP0_REG_*), ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12), Status/Cause bit positions.
//  One sub-module: cp0_timer (divider, Count, Compare, TI), instantiated only under CP0_TIMER_EN.
// TESTING
//  1. rst, then raddr 12 -> rdata 32'h0040_0000; raddr 14 -> 0; int_req_o=0.
//  2. exc_valid, code 8, pc 32'h8000_0010, in_delay=1 -> next cycle EPC=32'h8000_000C, Cause=32'h8000_0020, Status.EXL=1.
//     Then a second exception, code 10, pc 0x100 -> EPC unchanged, ExcCode=10.
//  3. eret while we_i writes EPC=0x1234 in the same cycle -> EXL=0, EPC unchanged.
//     mtc0 Status=0x0000_0401 then int_i=6'b000001 -> int_req_o=1; set EXL by exception -> int_req_o=0.
//  4. exc code 4, bad_addr 32'hBFC0_0003 -> BadVAddr=32'hBFC0_0003.
//     mtc0 to reg 8 with 0 -> BadVAddr unchanged; we_i+raddr=waddr=14, wdata 0xABCD -> rdata_o=0xABCD same cycle.
//  5. CP0_TIMER_EN, COUNT_DIV=2: write Count=10, Compare=12 -> TI=1 about 4-5 clocks later, timer_int_o=1.
//     Then write Compare=100 -> TI=0 next cycle. Write Count=32'hFFFF_FFFF -> Count=0 after 2 clocks.
//  6. CP0_TIMER_EN undefined: write Count=5 -> reads 0; timer_int_o stays 0 for 1000 cycles.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// Shared definitions for the CP0 register file: register numbers, ExcCodes,
// Status/Cause bit positions and write masks.
package cp0_regfile_pkg;

    typedef enum logic [4:0] {
        CP0_REG_BADVADDR = 5'd8,
        CP0_REG_COUNT    = 5'd9,
        CP0_REG_COMPARE  = 5'd11,
        CP0_REG_STATUS   = 5'd12,
        CP0_REG_CAUSE    = 5'd13,
        CP0_REG_EPC      = 5'd14
    } cp0_reg_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    // Status as seen by software: BEV is hardwired to 1, only IM/EXL/IE are stored.
    function automatic logic [31:0] status_pack(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        logic [31:0] s;
        s             = '0;
        s[STATUS_BEV] = 1'b1;
        s[15:8]       = im;
        s[STATUS_EXL] = exl;
        s[STATUS_IE]  = ie;
        return s;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with clock divider and TI flag; compiled and used only
// when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic DIV_LAST = 1'(COUNT_DIV - 1);

    logic div_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div_q <= 1'b0;
            end else if (div_q == DIV_LAST) begin
                count <= count + 32'd1;
                div_q <= 1'b0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (compare_we) begin
                compare <= wdata;
            end

            // A Compare write acknowledges the timer and beats a coincident match.
            if (compare_we) begin
                ti <= 1'b0;
            end else if ((count == compare) && (compare != '0)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception/eret bookkeeping, mfc0/mtc0 access and
// interrupt request. Define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic        eret_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_req_o,
    output logic        timer_int_o
);

    if (COUNT_DIV != 1 && COUNT_DIV != 2) begin : g_bad_count_div
        $error("cp0_regfile: COUNT_DIV must be 1 or 2");
    end

    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    // An exception or eret in the same cycle swallows the mtc0.
    logic wr_en;
    assign wr_en = we_i & ~exc_valid_i & ~eret_i;

`ifdef CP0_TIMER_EN
    logic count_we;
    logic compare_we;
    assign count_we   = wr_en && (waddr_i == CP0_REG_COUNT);
    assign compare_we = wr_en && (waddr_i == CP0_REG_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= RESET_STATUS[15:8];
            exl_q      <= RESET_STATUS[STATUS_EXL];
            ie_q       <= RESET_STATUS[STATUS_IE];
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            ip_hw_q <= int_i;
            if (exc_valid_i) begin
                // A nested exception keeps the original return point.
                if (!exl_q) begin
                    epc_q <= in_delay_i ? pc_i - 32'd4 : pc_i;
                    bd_q  <= in_delay_i;
                end
                exl_q      <= 1'b1;
                exc_code_q <= exc_code_i;
                if (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES) begin
                    badvaddr_q <= bad_addr_i;
                end
            end else if (eret_i) begin
                exl_q <= 1'b0;
            end else if (we_i) begin
                case (waddr_i)
                    CP0_REG_STATUS: begin
                        im_q  <= wdata_i[15:8];
                        exl_q <= wdata_i[STATUS_EXL];
                        ie_q  <= wdata_i[STATUS_IE];
                    end
                    CP0_REG_CAUSE: ip_sw_q <= wdata_i[9:8];
                    CP0_REG_EPC:   epc_q   <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

    assign status_o    = status_pack(im_q, exl_q, ie_q);
    assign epc_o       = epc_q;
    assign timer_int_o = ti;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cause_o             = '0;
        cause_o[CAUSE_BD]   = bd_q;
        cause_o[CAUSE_TI]   = ti;
        cause_o[15:10]      = ip_hw_q;
        cause_o[15]         = ip_hw_q[5] | ti;
        cause_o[9:8]        = ip_sw_q;
        cause_o[6:2]        = exc_code_q;
    end

    assign int_req_o = ie_q & ~exl_q & (|(cause_o[15:8] & im_q));

    // Post-write view of each register; raddr then picks from it, which gives
    // same-cycle forwarding when waddr_i matches raddr_i.
    logic [31:0] rd_status;
    logic [31:0] rd_cause;
    logic [31:0] rd_epc;
    logic [31:0] rd_count;
    logic [31:0] rd_compare;

    always_comb begin
        rd_status  = status_o;
        rd_cause   = cause_o;
        rd_epc     = epc_q;
        rd_count   = count;
        rd_compare = compare;
        if (we_i) begin
            case (waddr_i)
                CP0_REG_STATUS: rd_status = status_pack(wdata_i[15:8], wdata_i[STATUS_EXL],
                                                        wdata_i[STATUS_IE]);
                CP0_REG_CAUSE:  rd_cause  = {cause_o[31:10], wdata_i[9:8], cause_o[7:0]};
                CP0_REG_EPC:    rd_epc    = wdata_i;
`ifdef CP0_TIMER_EN
                CP0_REG_COUNT:   rd_count   = wdata_i;
                CP0_REG_COMPARE: rd_compare = wdata_i;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_REG_BADVADDR: rdata_o = badvaddr_q;
            CP0_REG_COUNT:    rdata_o = rd_count;
            CP0_REG_COMPARE:  rdata_o = rd_compare;
            CP0_REG_STATUS:   rdata_o = rd_status;
            CP0_REG_CAUSE:    rdata_o = rd_cause;
            CP0_REG_EPC:      rdata_o = rd_epc;
            default:          rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized
// traffic against a register-level reference model.
module tb_cp0_regfile;

    localparam int unsigned COUNT_DIV = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] pc_i;
    logic        in_delay_i;
    logic [31:0] bad_addr_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req_o;
    logic        timer_int_o;

    int checks = 0;
    int failures = 0;

    cp0_regfile #(
        .RESET_STATUS (32'h0040_0000),
        .COUNT_DIV    (COUNT_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .int_i       (int_i),
        .exc_valid_i (exc_valid_i),
        .exc_code_i  (exc_code_i),
        .eret_i      (eret_i),
        .pc_i        (pc_i),
        .in_delay_i  (in_delay_i),
        .bad_addr_i  (bad_addr_i),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .int_req_o   (int_req_o),
        .timer_int_o (timer_int_o)
    );

    always #5 clk = ~clk;

    // Reference model: whole 32-bit register images plus the timer phase.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_ti;
    logic [5:0]  m_ip;
    int unsigned m_phase;

    function automatic logic [31:0] model_cause();
        logic [31:0] c;
        c        = m_cause & 32'h8000_037C;
        c[30]    = m_ti;
        c[15:10] = m_ip;
        c[15]    = m_ip[5] | m_ti;
        return c;
    endfunction

    function automatic logic model_int_req();
        logic [31:0] c;
        c = model_cause();
        return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic fwd;
        fwd = we_i && (waddr_i == a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return TIMER ? (fwd ? wdata_i : m_count) : 32'd0;
            5'd11: return TIMER ? (fwd ? wdata_i : m_compare) : 32'd0;
            5'd12: return fwd ? ((wdata_i & 32'h0000_FF03) | 32'h0040_0000) : m_status;
            5'd13: return fwd ? ((model_cause() & ~32'h300) | (wdata_i & 32'h300)) : model_cause();
            5'd14: return fwd ? wdata_i : m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: model computes next state from the inputs the DUT samples.
    task automatic tick();
        logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
        logic        n_ti, ew;
        int unsigned n_phase;
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
        n_count = m_count; n_compare = m_compare; n_ti = m_ti; n_phase = m_phase;
        if (rst) begin
            n_status = 32'h0040_0000; n_cause = 0; n_epc = 0; n_badv = 0;
            n_count = 0; n_compare = 0; n_ti = 0; n_phase = 0;
        end else begin
            ew = we_i && !exc_valid_i && !eret_i;
            if (TIMER) begin
                if (ew && waddr_i == 5'd11) n_ti = 1'b0;
                else if (m_count == m_compare && m_compare != 0) n_ti = 1'b1;
                if (ew && waddr_i == 5'd9) begin
                    n_count = wdata_i;
                    n_phase = 0;
                end else begin
                    n_phase = (m_phase + 1) % COUNT_DIV;
                    if (n_phase == 0) n_count = m_count + 1;
                end
                if (ew && waddr_i == 5'd11) n_compare = wdata_i;
            end
            if (exc_valid_i) begin
                if (!m_status[1]) begin
                    n_epc = in_delay_i ? pc_i - 4 : pc_i;
                    n_cause[31] = in_delay_i;
                end
                n_status[1] = 1'b1;
                n_cause[6:2] = exc_code_i;
                if (exc_code_i == 5'd4 || exc_code_i == 5'd5) n_badv = bad_addr_i;
            end else if (eret_i) begin
                n_status[1] = 1'b0;
            end else if (ew) begin
                if (waddr_i == 5'd12) n_status = (wdata_i & 32'h0000_FF03) | 32'h0040_0000;
                if (waddr_i == 5'd13) n_cause = (m_cause & ~32'h300) | (wdata_i & 32'h300);
                if (waddr_i == 5'd14) n_epc = wdata_i;
            end
        end
        @(posedge clk);
        #1;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
        m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_phase = n_phase;
        m_ip = rst ? 6'd0 : int_i;
    endtask

    task automatic idle_inputs();
        we_i = 0; waddr_i = 0; wdata_i = 0; exc_valid_i = 0; exc_code_i = 0;
        eret_i = 0; pc_i = 0; in_delay_i = 0; bad_addr_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); int_i = 0; raddr_i = 0;
        tick(); tick();
        rst = 0;
        raddr_i = 5'd12; #1;
        checks++; if (rdata_o !== 32'h0040_0000) begin failures++; $display("FAIL reset_status_read: got %h want %h", rdata_o, 32'h0040_0000); end
        raddr_i = 5'd14; #1;
        checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL reset_epc_read: got %h want 0", rdata_o); end
        checks++; if (int_req_o !== 1'b0) begin failures++; $display("FAIL reset_int_req: got %b want 0", int_req_o); end
        checks++; if (cause_o !== 32'd0) begin failures++; $display("FAIL reset_cause: got %h want 0", cause_o); end
    endtask

    task automatic test_exception();
        exc_valid_i = 1; exc_code_i = 5'd8; pc_i = 32'h8000_0010; in_delay_i = 1;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'h8000_000C) begin failures++; $display("FAIL exc_epc_delay: got %h want %h", epc_o, 32'h8000_000C); end
        checks++; if (cause_o !== 32'h8000_0020) begin failures++; $display("FAIL exc_cause: got %h want %h", cause_o, 32'h8000_0020); end
        checks++; if (status_o[1] !== 1'b1) begin failures++; $display("FAIL exc_exl_set: got %b want 1", status_o[1]); end
        exc_valid_i = 1; exc_code_i = 5'd10; pc_i = 32'h0000_0100;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'h8000_000C) begin failures++; $display("FAIL nested_epc_kept: got %h want %h", epc_o, 32'h8000_000C); end
        checks++; if (cause_o[6:2] !== 5'd10 || cause_o[31] !== 1'b1) begin failures++; $display("FAIL nested_cause: got %h want code 10 with BD", cause_o); end
    endtask

    task automatic test_eret_and_int();
        eret_i = 1; we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234;
        tick();
        idle_inputs();
        checks++; if (status_o[1] !== 1'b0) begin failures++; $display("FAIL eret_exl_clear: got %b want 0", status_o[1]); end
        checks++; if (epc_o !== 32'h8000_000C) begin failures++; $display("FAIL eret_drops_write: got %h want %h", epc_o, 32'h8000_000C); end
        we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401;
        tick();
        idle_inputs(); int_i = 6'b000001;
        tick();
        checks++; if (int_req_o !== 1'b1) begin failures++; $display("FAIL int_req_on: got %b want 1", int_req_o); end
        checks++; if (cause_o[10] !== 1'b1) begin failures++; $display("FAIL cause_ip2: got %b want 1", cause_o[10]); end
        exc_valid_i = 1; exc_code_i = 5'd0; pc_i = 32'h0000_0200;
        tick();
        idle_inputs();
        checks++; if (int_req_o !== 1'b0) begin failures++; $display("FAIL int_req_masked_by_exl: got %b want 0", int_req_o); end
        checks++; if (epc_o !== 32'h0000_0200) begin failures++; $display("FAIL int_epc: got %h want 200", epc_o); end
        int_i = 0;
    endtask

    task automatic test_badvaddr_forward();
        exc_valid_i = 1; exc_code_i = 5'd4; bad_addr_i = 32'hBFC0_0003; pc_i = 32'h0000_0300;
        tick();
        idle_inputs(); raddr_i = 5'd8; #1;
        checks++; if (rdata_o !== 32'hBFC0_0003) begin failures++; $display("FAIL badvaddr_capture: got %h want %h", rdata_o, 32'hBFC0_0003); end
        we_i = 1; waddr_i = 5'd8; wdata_i = 0;
        tick();
        idle_inputs(); #1;
        checks++; if (rdata_o !== 32'hBFC0_0003) begin failures++; $display("FAIL badvaddr_readonly: got %h want %h", rdata_o, 32'hBFC0_0003); end
        we_i = 1; waddr_i = 5'd14; raddr_i = 5'd14; wdata_i = 32'hABCD; #1;
        checks++; if (rdata_o !== 32'hABCD) begin failures++; $display("FAIL forward_epc: got %h want abcd", rdata_o); end
        waddr_i = 5'd12; raddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF; #1;
        checks++; if (rdata_o !== 32'h0040_FF03) begin failures++; $display("FAIL forward_status_mask: got %h want %h", rdata_o, 32'h0040_FF03); end
        waddr_i = 5'd14; wdata_i = 32'hABCD;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'hABCD) begin failures++; $display("FAIL epc_write: got %h want abcd", epc_o); end
        raddr_i = 5'd20; #1;
        checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL unmapped_read: got %h want 0", rdata_o); end
    endtask

    task automatic test_timer();
        int n;
        bit seen;
        we_i = 1; waddr_i = 5'd9; wdata_i = 32'd10;
        tick();
        waddr_i = 5'd11; wdata_i = 32'd12;
        tick();
        idle_inputs();
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            checks++; if (timer_int_o !== m_ti) begin failures++; $display("FAIL timer_track: got %b want %b", timer_int_o, m_ti); end
            if (timer_int_o === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != 4) begin failures++; $display("FAIL timer_fire_latency: got %0d clocks (seen=%0d) want 4", n, seen); end
        checks++; if (cause_o[30] !== 1'b1 || cause_o[15] !== 1'b1) begin failures++; $display("FAIL cause_ti_ip7: got %h want bits 30,15 set", cause_o); end
        we_i = 1; waddr_i = 5'd11; wdata_i = 32'd100;
        tick();
        idle_inputs();
        checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL compare_write_clears_ti: got %b want 0", timer_int_o); end
        we_i = 1; waddr_i = 5'd9; wdata_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs(); raddr_i = 5'd9; #1;
        checks++; if (rdata_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_load_max: got %h want ffffffff", rdata_o); end
        tick(); tick();
        checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL count_wrap: got %h want 0", rdata_o); end
    endtask

    task automatic test_timer_disabled();
        int bad;
        we_i = 1; waddr_i = 5'd9; wdata_i = 32'd5;
        tick();
        waddr_i = 5'd11; wdata_i = 32'd5;
        tick();
        idle_inputs(); raddr_i = 5'd9; #1;
        checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL count_disabled_read: got %h want 0", rdata_o); end
        raddr_i = 5'd11; #1;
        checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL compare_disabled_read: got %h want 0", rdata_o); end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (timer_int_o !== 1'b0 || cause_o[30] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL timer_disabled_quiet: %0d cycles with TI set, want 0", bad); end
    endtask

    task automatic test_random();
        logic [4:0] regs [7];
        regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        rst = 1; idle_inputs(); int_i = 0;
        tick();
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 79) == 0);
            exc_valid_i = ($urandom_range(0, 9) == 0);
            eret_i      = ($urandom_range(0, 7) == 0);
            we_i        = $urandom_range(0, 1);
            waddr_i     = regs[$urandom_range(0, 6)];
            raddr_i     = ($urandom_range(0, 2) == 0) ? waddr_i : regs[$urandom_range(0, 6)];
            wdata_i     = $urandom;
            if (waddr_i == 5'd11 && $urandom_range(0, 1)) wdata_i = m_count + $urandom_range(0, 6);
            if (waddr_i == 5'd9 && $urandom_range(0, 2) == 0) wdata_i = 32'hFFFF_FFFF - $urandom_range(0, 3);
            exc_code_i  = ($urandom_range(0, 1)) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom_range(0, 12));
            pc_i        = $urandom;
            in_delay_i  = $urandom_range(0, 1);
            bad_addr_i  = $urandom;
            int_i       = ($urandom_range(0, 1)) ? 6'($urandom) : 6'd0;
            #1;
            checks++; if (rdata_o !== model_read(raddr_i)) begin failures++; $display("FAIL rand_rdata[%0d] raddr=%0d: got %h want %h", i, raddr_i, rdata_o, model_read(raddr_i)); end
            checks++; if (status_o !== m_status) begin failures++; $display("FAIL rand_status[%0d]: got %h want %h", i, status_o, m_status); end
            checks++; if (cause_o !== model_cause()) begin failures++; $display("FAIL rand_cause[%0d]: got %h want %h", i, cause_o, model_cause()); end
            checks++; if (epc_o !== m_epc) begin failures++; $display("FAIL rand_epc[%0d]: got %h want %h", i, epc_o, m_epc); end
            checks++; if (int_req_o !== model_int_req()) begin failures++; $display("FAIL rand_int_req[%0d]: got %b want %b", i, int_req_o, model_int_req()); end
            checks++; if (timer_int_o !== m_ti) begin failures++; $display("FAIL rand_timer_int[%0d]: got %b want %b", i, timer_int_o, m_ti); end
            tick();
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        m_status = 0; m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0;
        m_compare = 0; m_ti = 0; m_ip = 0; m_phase = 0;
        test_reset();
        test_exception();
        test_eret_and_int();
        test_badvaddr_forward();
        if (TIMER) test_timer();
        else test_timer_disabled();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
